// File: rtl/i2s_rx_core.sv
// I2S receiver: deserializes MSB-first words per WS half-period into
// stereo frames and presents them on a valid/ready interface.
//
// Ports:
//   sck         bit clock, all logic on rising edge
//   reset_n     asynchronous active-low reset
//   ws          word select (0 = left, 1 = right)
//   sd          serial data, MSB first, one-bit delay after WS change
//   frame_ready consumer accepts the held frame
//   overrun_clr single-cycle pulse clearing overrun
//   left_data   left sample of held frame
//   right_data  right sample of held frame
//   frame_valid held frame available
//   overrun     sticky: a completed frame was dropped
//   synced      receiver aligned to a frame boundary
module i2s_rx_core #(
  parameter int DATA_W = 8
) (
  input  logic              sck,
  input  logic              reset_n,
  input  logic              ws,
  input  logic              sd,
  input  logic              frame_ready,
  input  logic              overrun_clr,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              frame_valid,
  output logic              overrun,
  output logic              synced
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2
  } state_e;

  state_e            state_q;
  logic              ws_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic              valid_q;
  logic              ovr_q;
  logic              sync_q;

  logic cnt_full;
  logic ws_edge;
  logic ws_fall;
  logic ws_rise;

  assign cnt_full = (cnt_q >= CNT_MAX);
  assign ws_edge  = ws ^ ws_q;
  assign ws_fall  = ws_q & ~ws;
  assign ws_rise  = ~ws_q & ws;

  // Word as it stands after this edge's bit lands; on a WS edge this
  // is the finalized outgoing word (its LSB slot arrives with the edge).
  always_comb begin
    word_d = word_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (!cnt_full && cnt_q == CW'(DATA_W - 1 - i)) begin
        word_d[i] = sd;
      end
    end
  end

  always_ff @(posedge sck or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= UNSYNC;
      ws_q    <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      ws_q <= ws;

      if (ws_edge) begin
        word_q <= '0;
        cnt_q  <= '0;
      end else begin
        word_q <= word_d;
        if (!cnt_full) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      if (overrun_clr) begin
        ovr_q <= 1'b0;
      end

      if (valid_q && frame_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        UNSYNC: begin
          if (ws_fall) begin
            state_q <= LEFT;
            sync_q  <= 1'b1;
          end
        end
        LEFT: begin
          if (ws_rise) begin
            state_q <= RIGHT;
            hold_q  <= word_d;
          end
        end
        RIGHT: begin
          if (ws_fall) begin
            state_q <= LEFT;
            // A frame taken on this same edge frees the slot.
            if (!valid_q || frame_ready) begin
              left_q  <= hold_q;
              right_q <= word_d;
              valid_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
        end
        default: state_q <= UNSYNC;
      endcase
    end
  end

  assign left_data   = left_q;
  assign right_data  = right_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;
  assign synced      = sync_q;

endmodule

// File: tb/tb_i2s_rx_core.sv
// Directed bench for i2s_rx_core: drives an I2S stream and checks
// frame alignment, slot lengths, overrun and reset behaviour.
module tb_i2s_rx_core;

  logic       sck = 1'b0;
  logic       reset_n;
  logic       ws;
  logic       sd;
  logic       frame_ready;
  logic       overrun_clr;
  logic [7:0] left_data;
  logic [7:0] right_data;
  logic       frame_valid;
  logic       overrun;
  logic       synced;

  int checks = 0;
  int errors = 0;
  int nfv;
  logic [7:0] last_l;
  logic [7:0] last_r;
  logic pend;
  logic rdy_nxt;
  logic rdy_pulse;
  logic clr_nxt;

  always #5 sck = ~sck;

  i2s_rx_core #(.DATA_W(8)) dut (
    .sck         (sck),
    .reset_n     (reset_n),
    .ws          (ws),
    .sd          (sd),
    .frame_ready (frame_ready),
    .overrun_clr (overrun_clr),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .overrun     (overrun),
    .synced      (synced)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sck period: observe outputs, then drive this cycle's inputs.
  task automatic cyc(input logic w, input logic s);
    @(negedge sck);
    if (frame_valid === 1'b1) begin
      nfv++;
      last_l = left_data;
      last_r = right_data;
    end
    ws = w;
    sd = s;
    frame_ready = rdy_nxt | rdy_pulse;
    rdy_pulse = 1'b0;
    overrun_clr = clr_nxt;
    clr_nxt = 1'b0;
  endtask

  // One WS half of n sck: first slot carries the previous word's LSB.
  task automatic half(input logic w,
                      input logic [31:0] d,
                      input int n);
    cyc(w, pend);
    for (int j = 1; j < n; j++) cyc(w, d[n-j]);
    pend = d[0];
  endtask

  task automatic frame(input logic [31:0] l,
                       input logic [31:0] r,
                       input int n);
    half(1'b0, l, n);
    half(1'b1, r, n);
  endtask

  initial begin
    reset_n = 1'b1;
    ws = 1'b0;
    sd = 1'b0;
    frame_ready = 1'b0;
    overrun_clr = 1'b0;
    pend = 1'b0;
    rdy_nxt = 1'b1;
    rdy_pulse = 1'b0;
    clr_nxt = 1'b0;
    nfv = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge sck);
    check("rst_left", left_data, 8'h00);
    check("rst_right", right_data, 8'h00);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_sync", synced, 1'b0);
    reset_n = 1'b1;

    // 8-bit slots
    half(1'b1, 32'h00, 8);
    check("t1_nosync_on_rise", synced, 1'b0);
    frame(32'hA5, 32'h3C, 8);
    check("t1_synced", synced, 1'b1);
    check("t1_no_frame_yet", nfv, 0);
    frame(32'hA5, 32'h3C, 8);
    frame(32'hA5, 32'h3C, 8);
    check("t1_nframes", nfv, 2);
    check("t1_left", last_l, 8'hA5);
    check("t1_right", last_r, 8'h3C);
    check("t1_valid_pulse", frame_valid, 1'b0);

    // 12-bit slots
    nfv = 0;
    frame(32'hA5F, 32'h3CF, 12);
    frame(32'hA5F, 32'h3CF, 12);
    check("t2_nframes", nfv, 2);
    check("t2_left", last_l, 8'hA5);
    check("t2_right", last_r, 8'h3C);

    // 6-bit slots
    nfv = 0;
    frame(32'h2D, 32'h13, 6);
    frame(32'h2D, 32'h13, 6);
    check("t3_nframes", nfv, 2);
    check("t3_left", last_l, 8'hB4);
    check("t3_right", last_r, 8'h4C);

    // Back-pressure and overrun
    frame(32'h11, 32'h22, 8);
    rdy_nxt = 1'b0;
    frame(32'h33, 32'h44, 8);
    check("t4_held_valid", frame_valid, 1'b1);
    check("t4_held_left", left_data, 8'h11);
    check("t4_held_right", right_data, 8'h22);
    check("t4_no_ovr", overrun, 1'b0);
    half(1'b0, 32'h55, 8);
    check("t4_ovr_set", overrun, 1'b1);
    check("t4_keep_valid", frame_valid, 1'b1);
    check("t4_keep_left", left_data, 8'h11);
    check("t4_keep_right", right_data, 8'h22);
    rdy_nxt = 1'b1;
    half(1'b1, 32'h66, 8);
    check("t4_hs_clear", frame_valid, 1'b0);
    check("t4_ovr_sticky", overrun, 1'b1);
    rdy_nxt = 1'b0;
    clr_nxt = 1'b1;
    half(1'b0, 32'h77, 8);
    check("t4_ovr_clr", overrun, 1'b0);
    check("t4_new_valid", frame_valid, 1'b1);
    check("t4_new_left", left_data, 8'h55);
    check("t4_new_right", right_data, 8'h66);

    // Handshake on the completing edge
    half(1'b1, 32'h88, 8);
    rdy_pulse = 1'b1;
    half(1'b0, 32'h99, 8);
    check("t5_valid", frame_valid, 1'b1);
    check("t5_left", left_data, 8'h77);
    check("t5_right", right_data, 8'h88);
    check("t5_ovr", overrun, 1'b0);

    // Drop and clear on the same edge: set wins
    half(1'b1, 32'hAA, 8);
    clr_nxt = 1'b1;
    half(1'b0, 32'hBB, 8);
    check("t5_set_wins", overrun, 1'b1);
    check("t5_drop_keep", left_data, 8'h77);
    rdy_nxt = 1'b1;
    half(1'b1, 32'hCC, 8);
    check("t5_consumed", frame_valid, 1'b0);

    // Reset mid right word
    half(1'b0, 32'hDD, 8);
    check("t6_pre_left", left_data, 8'hBB);
    cyc(1'b1, pend);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_left", left_data, 8'h00);
    check("t6_rst_right", right_data, 8'h00);
    check("t6_rst_valid", frame_valid, 1'b0);
    check("t6_rst_ovr", overrun, 1'b0);
    check("t6_rst_sync", synced, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    reset_n = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("t6_unsync", synced, 1'b0);
    nfv = 0;
    pend = 1'b0;
    frame(32'h12, 32'h34, 8);
    check("t6_resync", synced, 1'b1);
    check("t6_partial_drop", nfv, 0);
    frame(32'h56, 32'h78, 8);
    check("t6_nframes", nfv, 1);
    check("t6_left", last_l, 8'h12);
    check("t6_right", last_r, 8'h34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
